// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port unified memory.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of data priority with a starvation guard.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt,
  // which pulses for one cycle in IDLE or DONE; rvalid pulses exactly two cycles later.
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t state, state_nx;
  owner_t owner;
  logic   lat_we;
  logic   arb_en;
  logic   pick_if;
  logic   pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On a tie, whichever port was not served most recently wins.
  always_comb begin
    arb_en  = rst && (state != S_ACCESS);
    pick_if = arb_en && if_req && (!d_req || last_d);
    pick_d  = arb_en && d_req && !pick_if;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b1;
    end else if (pick_if) begin
      last_d <= 1'b0;
    end else if (pick_d) begin
      last_d <= 1'b1;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve;

  always_comb begin
    arb_en  = rst && (state != S_ACCESS);
    pick_if = arb_en && if_req && (!d_req || (starve == STARVE_LIM));
    pick_d  = arb_en && d_req && !pick_if;
  end

  // Counts fetch losses to data; saturates so fetch eventually wins outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= 4'd0;
    end else if (pick_if) begin
      starve <= 4'd0;
    end else if (pick_d && if_req && (starve < STARVE_LIM)) begin
      starve <= starve + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    if_gnt    = pick_if;
    d_gnt     = pick_d;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pick_if || pick_d) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        mem_read  = !lat_we;
        mem_write = lat_we;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        if_rvalid = (owner == OWN_IF);
        d_rvalid  = (owner == OWN_D);
        state_nx  = (pick_if || pick_d) ? S_ACCESS : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Address/data are latched straight into the memory-facing registers at grant,
  // so they hold their last values between accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_NONE;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (pick_if || pick_d) begin
        owner    <= pick_if ? OWN_IF : OWN_D;
        lat_we   <= pick_d && d_we;
        mem_addr <= pick_if ? if_addr : d_addr;
        if (pick_d && d_we) mem_wdata <= d_wdata;
      end else if (state == S_DONE) begin
        owner  <= OWN_NONE;
        lat_we <= 1'b0;
      end
      if (state == S_ACCESS && !lat_we) begin
        if (owner == OWN_IF) if_rdata <= mem_rdata;
        else if (owner == OWN_D) d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a small behavioural memory.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_model [0:255];
  logic          mem_init;
  logic [1:0]    exp_q[$];
  logic [1:0]    got_q[$];

  unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // memory: combinational read, write commits at the rising edge
  assign mem_rdata = mem_model[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= '0;
      mem_model[0]  <= 32'h10011800;
      mem_model[40] <= 32'd69;
    end else if (mem_write) begin
      mem_model[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_gnt;
    int n_wr;
    int n_rv;
    rst = 1'b0; mem_init = 1'b1;
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // reset with a pending fetch
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_eq("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check_eq("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check_eq("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("c1_if_gnt", {31'd0, if_gnt}, 32'd1);
    check_eq("c1_mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    check_eq("c2_mem_read", {31'd0, mem_read}, 32'd1);
    check_eq("c2_mem_addr", mem_addr, 32'd0);
    check_eq("c2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("c3_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check_eq("c3_if_rdata", if_rdata, 32'h10011800);
    check_eq("c3_mem_read", {31'd0, mem_read}, 32'd0);

    // load from 40
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'd40;
    @(negedge clk);
    check_eq("ld_d_gnt", {31'd0, d_gnt}, 32'd1);
    check_eq("ld_if_gnt", {31'd0, if_gnt}, 32'd0);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    check_eq("ld_mem_read", {31'd0, mem_read}, 32'd1);
    check_eq("ld_mem_addr", mem_addr, 32'd40);
    check_eq("ld_mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    check_eq("ld_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("ld_d_rdata", d_rdata, 32'd69);
    check_eq("ld_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check_eq("ld_if_rdata", if_rdata, 32'h10011800);

    // store 10 to 5, then load 5 back-to-back
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'd10;
    @(negedge clk);
    check_eq("st_d_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1 d_we = 1'b0; d_wdata = 32'd0;
    @(negedge clk);
    check_eq("st_mem_rw", {30'd0, mem_read, mem_write}, 32'd1);
    check_eq("st_mem_wdata", mem_wdata, 32'd10);
    check_eq("st_mem_addr", mem_addr, 32'd5);
    check_eq("st_gnt_in_access", {31'd0, d_gnt}, 32'd0);
    @(negedge clk);
    check_eq("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("st_b2b_gnt", {31'd0, d_gnt}, 32'd1);
    check_eq("st_d_rdata_kept", d_rdata, 32'd69);
    check_eq("st_done_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    check_eq("rb_mem_rw", {30'd0, mem_read, mem_write}, 32'd2);
    check_eq("rb_mem_addr", mem_addr, 32'd5);
    @(negedge clk);
    check_eq("rb_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("rb_d_rdata", d_rdata, 32'd10);

    // both ports held: grant order (1 = data, 0 = fetch)
`ifdef MEM_ARB_RR_EN
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`endif
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'd40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd0;
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) check_eq("gnt_excl", 32'd1, 32'd0);
      if (if_gnt) got_q.push_back(2'd0);
      if (d_gnt) got_q.push_back(2'd1);
    end
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    check_eq("arb_gnt_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("arb_order_%0d", i), (i < got_q.size()) ? {30'd0, got_q[i]} : 32'd3, {30'd0, exp_q[i]});
    repeat (3) @(posedge clk);

    // reset during the access cycle of a store to 8
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'd77;
    @(negedge clk);
    check_eq("rs_d_gnt", {31'd0, d_gnt}, 32'd1);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check_eq("rs_mem_write", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("rs_async_write", {31'd0, mem_write}, 32'd0);
    check_eq("rs_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    n_rv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("rs_busy_after", {31'd0, busy}, 32'd0);
      if (d_rvalid) n_rv++;
    end
    check_eq("rs_no_rvalid", n_rv, 32'd0);
    check_eq("rs_no_commit", mem_model[8], 32'd0);

    // data request pulsed during an access and dropped before any grant
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'd0;
    @(negedge clk);
    check_eq("pl_if_gnt", {31'd0, if_gnt}, 32'd1);
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'd99;
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    n_gnt = 0; n_wr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_gnt) n_gnt++;
      if (mem_write) n_wr++;
    end
    check_eq("pl_no_gnt", n_gnt, 32'd0);
    check_eq("pl_no_write", n_wr, 32'd0);
    check_eq("pl_mem12", mem_model[12], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage (read-only port "if") and the load/store stage (read/write port "d").
- Sequences every access as request/grant, then one memory-access cycle, then a registered response.
- Drives the memory's addr/WriteData/MemRead/MemWrite pins and samples its combinational read data.
- Sits between the pipeline front/back ends and the memory block.

Parameters:
- AW, 32, address width (byte address, passed to memory unchanged).
- DW, 32, data width.
- STARVE_MAX, 3, consecutive fetch losses after which fetch wins the next arbitration (range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  AW  fetch address; stable while if_req is high.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DW  fetched word; holds last value otherwise.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = store, 0 = load; qualified by d_req.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: load data valid, or store completed.
- d_rdata  output  DW  load data; unchanged on store completion.
- mem_addr  output  AW  to memory addr.
- mem_wdata  output  DW  to memory WriteData.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_rdata  input  DW  from memory data (combinational).
- busy  output  1  high in ACCESS and DONE.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - all outputs to 0: gnt, rvalid, rdata, mem_*, busy;
  - state to IDLE, starve counter to 0, owner to NONE.
  - An in-flight transaction is dropped; no rvalid is issued after reset release.
- FSM states:
  - IDLE: arbitrate among pending requests. On a winner: pulse its gnt, latch addr/we/wdata and owner, go to ACCESS. With no request, stay in IDLE.
  - ACCESS: exactly one cycle.
    - mem_addr = latched address.
    - Load/fetch: mem_read=1. Store: mem_write=1 and mem_wdata = latched data; memory commits at the closing clock edge.
    - At the closing edge, a read captures mem_rdata into the owner's rdata register.
    - Go to DONE.
  - DONE: pulse the owner's rvalid; mem_read = mem_write = 0. Arbitrate again in the same cycle:
    - if a request is pending, pulse its gnt and go to ACCESS (back-to-back, 2 cycles per access);
    - otherwise go to IDLE.
- Latency: gnt in cycle N, memory access in cycle N+1, rvalid in cycle N+2.
- mem_read and mem_write are never both high. Both are low outside ACCESS. mem_addr and mem_wdata hold their last values outside ACCESS.
- Arbitration (default):
  - Data has fixed priority over fetch.
  - Every arbitration where if_req=1 and data wins increments the starve counter, saturating at STARVE_MAX.
  - When counter = STARVE_MAX, fetch wins even if d_req=1.
  - Counter clears whenever fetch is granted.
- Simultaneous if_req and d_req with counter < STARVE_MAX: data granted; fetch stays pending with if_req held.
- Requests that deassert before gnt are ignored, with no side effects. A request asserted during ACCESS is considered in the following DONE cycle.
- Writes to the same address that a following fetch reads return the new data, because of the DONE-then-ACCESS ordering.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - The starve counter is removed.
  - Arbitration is round-robin: on a tie, the requester not granted most recently wins. After reset, data is treated as most recent, so fetch wins the first tie.
- Undefined: fixed data priority with the STARVE_MAX guard, as above.

Test Plan:
- Reset with if_req=1, if_addr=0 -> all outputs 0 during reset. After release: if_gnt at cycle 1, mem_read=1 and mem_addr=0 at cycle 2, if_rvalid=1 with if_rdata=32'h10011800 at cycle 3.
- Load d_addr=40 (memory holds 69) -> d_gnt, then ACCESS with mem_read=1, then d_rvalid=1 with d_rdata=69; fetch port untouched.
- Store d_we=1, d_addr=5, d_wdata=10, then load d_addr=5 back-to-back -> mem_write=1 for exactly one cycle; the second d_gnt coincides with the first d_rvalid; load returns 10.
- if_req and d_req held continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I. With MEM_ARB_RR_EN the order is I,D,I,D.
- rst asserted during ACCESS of a store to address 8 -> no d_rvalid. After release, state is IDLE and busy=0.
- d_req pulsed one cycle while busy, dropped before gnt -> no d_gnt and no memory access.
